axi4_sram_slave: RTL and testbench

AXI4 responder (slave) fronting a word-addressed SRAM model. It is the target the LSU/IFU masters talk to on the CPU data bus in simulation and FPGA builds. Read and write channels run independent FSMs with programmable response latency, INCR/FIXED bursts, byte-strobed writes and SLVERR on bad accesses. Reads always return the full 32-bit word; the master does lane selection and sign extension.

---
 rtl/axi4_pkg.sv | 17 +
 rtl/byte_en_sram.sv | 22 ++
 rtl/axi4_sram_slave.sv | 141 ++++++++++++++
 tb/tb_axi4_sram_slave.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_pkg.sv
// axi4_pkg: AXI4 burst/response encodings, FSM state types and address decode helpers.
package axi4_pkg;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] BURST_WRAP = 2'b10;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_LAT, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_LAT, R_DATA} rd_state_t;
  function automatic logic addr_in_range(input logic [31:0] addr, input logic [31:0] base,
                                         input logic [31:0] words);
    return addr >= base && ((addr - base) >> 2) < words;
  endfunction
  function automatic logic burst_bad(input logic [1:0] burst);
    return burst == BURST_WRAP || burst == 2'b11;
  endfunction
endpackage

// File: rtl/byte_en_sram.sv
// byte_en_sram: word SRAM with a byte-enabled write port and a registered read port.
module byte_en_sram #(
  parameter int WORDS = 4096,
  localparam int AW = $clog2(WORDS)
) (
  input  logic          clock,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic [3:0]    i_wbe,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);
  logic [31:0] r_mem [WORDS];
  // Read samples the array before this edge's write lands, so same-cycle reads see old data.
  always_ff @(posedge clock) begin
    for (int i = 0; i < 4; i++)
      if (i_we && i_wbe[i]) r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
    if (i_re) o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/axi4_sram_slave.sv
// axi4_sram_slave: AXI4 responder over a byte-enabled SRAM with independent read/write FSMs.
module axi4_sram_slave import axi4_pkg::*; #(
  parameter logic [31:0] ADDR_BASE = 32'h8000_0000,
  parameter int MEM_WORDS = 4096,
  parameter int RD_LATENCY = 1,
  parameter int WR_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awid,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp,
  output logic [3:0]  bid,
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  input  logic [3:0]  arid,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic [3:0]  rid
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam logic [31:0] WORDS = 32'(MEM_WORDS);
  wr_state_t r_wst, w_wst_next;
  rd_state_t r_rst, w_rst_next;
  logic [31:0] r_waddr, r_raddr, w_rnext, w_faddr, w_mem_rdata;
  logic [7:0] r_awlen, r_wbeat, r_arlen, r_rbeat;
  logic [3:0] r_bid, r_rid, r_wcnt, r_rcnt;
  logic [1:0] r_awburst, r_arburst, w_fburst;
  logic r_werr, r_wover, r_rerr, w_wend, w_win, w_we, w_fetch, w_rend, w_unused;
  assign w_unused = ^{awsize, arsize};
  always_ff @(posedge clock) r_wst <= reset ? W_IDLE : w_wst_next;
  always_ff @(posedge clock) r_rst <= reset ? R_IDLE : w_rst_next;
  always_comb begin
    awready = r_wst == W_IDLE;
    wready = r_wst == W_DATA;
    bvalid = r_wst == W_RESP;
    bresp = r_werr ? RESP_SLVERR : RESP_OKAY;
    bid = r_bid;
    w_wend = r_wbeat == r_awlen;
    w_win = addr_in_range(r_waddr, ADDR_BASE, WORDS);
    w_we = wvalid && wready && !r_wover && !burst_bad(r_awburst) && w_win;
    w_wst_next = r_wst == W_IDLE ? (awvalid ? W_DATA : W_IDLE)
               : r_wst == W_DATA ? (wvalid && wlast ? (WR_LATENCY == 0 ? W_RESP : W_LAT) : W_DATA)
               : r_wst == W_LAT  ? (r_wcnt == 4'(WR_LATENCY - 1) ? W_RESP : W_LAT)
               : (bready ? W_IDLE : W_RESP);
  end
  // Beat counter stops at awlen; wlast disagreeing with it flags an error either way.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_bid <= '0;
      r_werr <= 1'b0;
    end else begin
      if (awvalid && awready) begin
        r_waddr <= awaddr;
        r_bid <= awid;
        r_awlen <= awlen;
        r_awburst <= awburst;
        r_wbeat <= '0;
        r_werr <= burst_bad(awburst);
        r_wover <= 1'b0;
        r_wcnt <= '0;
      end
      if (wvalid && wready) begin
        if (r_awburst == BURST_INCR) r_waddr <= r_waddr + 32'd4;
        if (!w_wend) r_wbeat <= r_wbeat + 8'd1;
        r_wover <= r_wover || (!wlast && w_wend);
        if (!w_win || wlast != w_wend) r_werr <= 1'b1;
      end
      if (r_wst == W_LAT) r_wcnt <= r_wcnt + 4'd1;
    end
  end
  always_comb begin
    arready = r_rst == R_IDLE;
    rvalid = r_rst == R_DATA;
    w_rend = r_rbeat == r_arlen;
    rlast = rvalid && w_rend;
    rresp = rvalid && r_rerr ? RESP_SLVERR : RESP_OKAY;
    rdata = rvalid && !r_rerr ? w_mem_rdata : 32'd0;
    rid = r_rid;
    w_rnext = r_arburst == BURST_FIXED ? r_raddr : r_raddr + 32'd4;
    w_faddr = r_rst == R_IDLE ? araddr : r_rst == R_DATA ? w_rnext : r_raddr;
    w_fburst = r_rst == R_IDLE ? arburst : r_arburst;
    // Fetch lands one cycle before each beat: end of latency, or the handshake of the prior beat.
    w_fetch = r_rst == R_IDLE ? arvalid && RD_LATENCY == 0
            : r_rst == R_LAT ? r_rcnt == 4'(RD_LATENCY - 1)
            : rready && !w_rend;
    w_rst_next = r_rst == R_IDLE ? (arvalid ? (RD_LATENCY == 0 ? R_DATA : R_LAT) : R_IDLE)
               : r_rst == R_LAT ? (r_rcnt == 4'(RD_LATENCY - 1) ? R_DATA : R_LAT)
               : (rready && w_rend ? R_IDLE : R_DATA);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rid <= '0;
      r_rerr <= 1'b0;
    end else begin
      if (arvalid && arready) begin
        r_raddr <= araddr;
        r_rid <= arid;
        r_arlen <= arlen;
        r_arburst <= arburst;
        r_rbeat <= '0;
        r_rcnt <= '0;
      end
      if (r_rst == R_LAT) r_rcnt <= r_rcnt + 4'd1;
      if (rvalid && rready) begin
        r_raddr <= w_rnext;
        r_rbeat <= r_rbeat + 8'd1;
      end
      if (w_fetch) r_rerr <= burst_bad(w_fburst) || !addr_in_range(w_faddr, ADDR_BASE, WORDS);
    end
  end
  byte_en_sram #(.WORDS(MEM_WORDS)) u_sram (
    .clock  (clock),
    .i_we   (w_we),
    .i_waddr(AW'((r_waddr - ADDR_BASE) >> 2)),
    .i_wdata(wdata),
    .i_wbe  (wstrb),
    .i_re   (w_fetch),
    .i_raddr(AW'((w_faddr - ADDR_BASE) >> 2)),
    .o_rdata(w_mem_rdata)
  );
endmodule

// File: tb/tb_axi4_sram_slave.sv
// tb_axi4_sram_slave: directed and random AXI4 traffic checked against a word-array model.
module tb_axi4_sram_slave;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int WORDS = 4096, RL = 3, WL = 2;
  logic clock = 0, reset = 1;
  logic awvalid = 0, awready, wvalid = 0, wready, wlast = 0, bvalid, bready = 0;
  logic arvalid = 0, arready, rvalid, rready = 0, rlast;
  logic [31:0] awaddr = 0, wdata = 0, araddr = 0, rdata;
  logic [3:0] awid = 0, wstrb = 0, bid, arid = 0, rid;
  logic [7:0] awlen = 0, arlen = 0;
  logic [2:0] awsize = 3'd2, arsize = 3'd2;
  logic [1:0] awburst = 0, arburst = 0, bresp, rresp;
  int ncmp = 0, nfail = 0, cyc = 0;
  logic [31:0] mdl [WORDS];
  logic [31:0] wd [300];
  logic [3:0] ws [300];

  always #5 clock = ~clock;

  axi4_sram_slave #(.ADDR_BASE(BASE), .MEM_WORDS(WORDS), .RD_LATENCY(RL), .WR_LATENCY(WL)) dut (
    .clock(clock), .reset(reset),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rid(rid)
  );

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_rng(input longint a);
    return a >= longint'(BASE) && a < longint'(BASE) + 4 * WORDS;
  endfunction

  function automatic longint beat_addr(input logic [31:0] a, input logic [1:0] b, input int i);
    return longint'(a) + (b == 2'b01 ? 4 * i : 0);
  endfunction

  function automatic int widx(input longint a);
    return int'((a - longint'(BASE)) >> 2);
  endfunction

  // Beats 0..min(k,len) are the real ones; wlast at beat k, any mismatch or stray address is SLVERR.
  task automatic axi_write(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                           input logic [1:0] burst, input int k, input int hold);
    bit err;
    int n, t, w;
    longint a;
    err = burst[1] || k != int'(len);
    n = k < int'(len) ? k : int'(len);
    for (int i = 0; i <= n; i++) begin
      a = beat_addr(addr, burst, i);
      if (!in_rng(a)) err = 1;
      else if (!burst[1])
        for (int b = 0; b < 4; b++) if (ws[i][b]) mdl[widx(a)][8*b +: 8] = wd[i][8*b +: 8];
    end
    awvalid = 1; awaddr = addr; awid = id; awlen = len; awburst = burst;
    w = 0;
    while (!awready && w < 100) begin step(); w++; end
    chk("awready", awready, 1);
    step();
    awvalid = 0;
    chk("aw_busy", awready, 0);
    for (int i = 0; i <= k; i++) begin
      wvalid = 1; wdata = wd[i]; wstrb = ws[i]; wlast = i == k;
      w = 0;
      while (!wready && w < 100) begin step(); w++; end
      if (w == 100) chk("wready", wready, 1);
      step();
    end
    wvalid = 0; wlast = 0;
    t = cyc;
    w = 0;
    while (!bvalid && w < 100) begin step(); w++; end
    chk("b_latency", cyc - t, WL);
    for (int h = 0; h < hold; h++) begin
      chk("b_hold_valid", bvalid, 1);
      chk("b_hold_resp", bresp, err ? 2 : 0);
      step();
    end
    bready = 1;
    chk("bvalid", bvalid, 1);
    chk("bresp", bresp, err ? 2 : 0);
    chk("bid", bid, id);
    step();
    bready = 0;
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                          input logic [1:0] burst, input int stall0, input bit rnd, input int abort_at);
    int t, w, s;
    longint a;
    bit oor, dchk;
    logic [31:0] ed;
    logic [1:0] er;
    arvalid = 1; araddr = addr; arid = id; arlen = len; arburst = burst;
    w = 0;
    while (!arready && w < 100) begin step(); w++; end
    chk("arready", arready, 1);
    step();
    arvalid = 0;
    t = cyc;
    for (int i = 0; i <= int'(len); i++) begin
      a = beat_addr(addr, burst, i);
      oor = !in_rng(a);
      er = burst[1] || oor ? 2'b10 : 2'b00;
      dchk = burst[1] || !oor;
      ed = burst[1] ? 32'd0 : (oor ? 32'd0 : mdl[widx(a)]);
      w = 0;
      while (!rvalid && w < 100) begin step(); w++; end
      if (i == 0) chk("r_latency", cyc - t, RL);
      else chk("r_back_to_back", w, 0);
      s = i == 0 ? stall0 : (rnd ? $urandom_range(0, 2) : 0);
      for (int h = 0; h < s; h++) begin
        chk("r_stall_valid", rvalid, 1);
        chk("r_stall_last", rlast, i == int'(len));
        chk("r_stall_resp", rresp, er);
        if (dchk) chk("r_stall_data", rdata, ed);
        step();
      end
      rready = 1;
      chk("rvalid", rvalid, 1);
      chk("rid", rid, id);
      chk("rlast", rlast, i == int'(len));
      chk("rresp", rresp, er);
      if (dchk) chk("rdata", rdata, ed);
      step();
      rready = 0;
      if (i == abort_at) return;
    end
  endtask

  initial begin
    int r, len_, s, bsel, k;
    logic [31:0] a;
    logic [1:0] b;
    repeat (3) step();
    chk("rst_awready", awready, 1);
    chk("rst_arready", arready, 1);
    chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rlast", rlast, 0);
    chk("rst_bresp", bresp, 0);
    chk("rst_rresp", rresp, 0);
    chk("rst_bid", bid, 0);
    chk("rst_rid", rid, 0);
    chk("rst_rdata", rdata, 0);
    reset = 0;
    step();
    // Preload the low window and the top eight words so every later read has known contents.
    for (int i = 0; i < 64; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    axi_write(BASE, 4'd1, 8'd63, 2'b01, 63, 0);
    for (int i = 0; i < 8; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    axi_write(BASE + 4 * 4088, 4'd2, 8'd7, 2'b01, 7, 0);
    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    axi_write(32'h8000_0010, 4'd5, 8'd0, 2'b01, 0, 0);
    axi_read(32'h8000_0010, 4'd9, 8'd0, 2'b01, 0, 0, -1);
    wd[0] = 32'h11223344; ws[0] = 4'hF;
    axi_write(32'h8000_0020, 4'd3, 8'd0, 2'b01, 0, 0);
    wd[0] = 32'h0000AB00; ws[0] = 4'b0010;
    axi_write(32'h8000_0020, 4'd3, 8'd0, 2'b01, 0, 0);
    axi_read(32'h8000_0020, 4'd4, 8'd0, 2'b01, 0, 0, -1);
    for (int i = 0; i < 4; i++) begin wd[i] = i + 1; ws[i] = 4'hF; end
    axi_write(32'h8000_0100, 4'd6, 8'd3, 2'b01, 3, 0);
    axi_read(32'h8000_0100, 4'd7, 8'd3, 2'b01, 0, 1, -1);
    for (int i = 0; i < 3; i++) begin wd[i] = 32'hA0 + i; ws[i] = 4'hF; end
    axi_write(32'h8000_0080, 4'd8, 8'd2, 2'b00, 2, 0);
    axi_read(32'h8000_0080, 4'd8, 8'd2, 2'b01, 0, 0, -1);
    wd[0] = 32'h55AA55AA; ws[0] = 4'hF;
    axi_write(32'h8000_0030, 4'hA, 8'd0, 2'b01, 0, 4);
    axi_read(32'h8000_0030, 4'hB, 8'd1, 2'b01, 5, 0, -1);
    wd[0] = 32'hBAD0BAD0; ws[0] = 4'hF;
    axi_write(32'h7FFF_FFFC, 4'hC, 8'd0, 2'b01, 0, 0);
    axi_read(32'h8000_0000, 4'hC, 8'd1, 2'b01, 0, 0, -1);
    axi_read(32'h8000_0040, 4'hD, 8'd1, 2'b10, 0, 0, -1);
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hC0 + i; ws[i] = 4'hF; end
    axi_write(32'h8000_0050, 4'hE, 8'd3, 2'b01, 1, 0);
    axi_read(32'h8000_0050, 4'hE, 8'd3, 2'b01, 0, 0, -1);
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 3);
      bsel = $urandom_range(0, 9);
      b = bsel < 6 ? 2'b01 : bsel < 8 ? 2'b00 : bsel == 8 ? 2'b10 : 2'b11;
      len_ = $urandom_range(0, 7);
      s = $urandom_range(0, 63 - len_);
      a = r < 2 ? BASE + 4 * s : r == 2 ? BASE + 4 * $urandom_range(4088, 4095)
                                        : BASE - 4 * $urandom_range(1, 2);
      a = a + $urandom_range(0, 3);
      k = $urandom_range(0, 7) == 0 ? $urandom_range(0, len_ + 2) : len_;
      for (int i = 0; i < 12; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
      if ($urandom_range(0, 1) == 1) axi_write(a, 4'($urandom), 8'(len_), b, k, $urandom_range(0, 2));
      else axi_read(a, 4'($urandom), 8'(len_), b, $urandom_range(0, 2), 1, -1);
    end
    axi_read(32'h8000_0100, 4'h3, 8'd3, 2'b01, 0, 0, 0);
    reset = 1;
    step();
    chk("mid_rst_rvalid", rvalid, 0);
    chk("mid_rst_rlast", rlast, 0);
    chk("mid_rst_arready", arready, 1);
    chk("mid_rst_bvalid", bvalid, 0);
    reset = 0;
    step();
    axi_read(32'h8000_0010, 4'h2, 8'd0, 2'b01, 0, 0, -1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
